// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-word output register plus one-word skid buffer.
// Latency 1 cycle from ihit to valid; a stalled output parks the returning word in HOLD.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_addr,
  output logic        pcenable,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] npc,
  output logic        valid,
  output logic [31:0] fetch_count
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } slot_t;

  state_t      state_q, state_d;
  slot_t       out_q, out_d;
  slot_t       skid_q, skid_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        out_free;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      out_q   <= '{word: 32'h0, pc: RESET_PC};
      skid_q  <= '0;
      valid_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_free = !valid_q || !stall;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      // Redirect: anything in flight or parked belongs to the wrong path.
      state_d = FETCH;
      valid_d = 1'b0;
      skid_d  = '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit) begin
            if (out_free) begin
              out_d   = '{word: imemload, pc: pc_addr};
              valid_d = 1'b1;
              count_d = count_q + 32'd1;
            end else begin
              skid_d  = '{word: imemload, pc: pc_addr};
              state_d = HOLD;
            end
          end else if (valid_q && !stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_d   = skid_q;
            valid_d = 1'b1;
            skid_d  = '0;
            count_d = count_q + 32'd1;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign pcenable    = !RST && (((state_q == FETCH) && ihit) || flush);
  assign imemREN     = !RST && !flush && (state_q == FETCH);
  assign imemaddr    = pc_addr;
  assign instr       = out_q.word;
  assign instr_pc    = out_q.pc;
  assign npc         = out_q.pc + 32'd4;
  assign valid       = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vectors, a queue-based delivery model checked
// every cycle, and hand-computed literal expectations at key points.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, flush;
  logic [31:0] pc_addr, imemload;
  logic        pcenable, imemREN, valid;
  logic [31:0] imemaddr, instr, instr_pc, npc, fetch_count;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .RST(RST), .pc_addr(pc_addr), .pcenable(pcenable),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .stall(stall), .flush(flush), .instr(instr), .instr_pc(instr_pc),
    .npc(npc), .valid(valid), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output register plus a FIFO of words accepted but not yet shown.
  bit          m_ok = 1'b0;
  bit          m_valid;
  logic [31:0] m_instr, m_pc, m_count;
  logic [63:0] m_parked[$];

  always @(negedge CLK) begin
    bit parked;
    parked = (m_parked.size() != 0);
    if (m_ok) begin
      chk("imemREN", {31'b0, imemREN}, {31'b0, !RST && !flush && !parked});
      chk("pcenable", {31'b0, pcenable}, {31'b0, !RST && ((ihit && !parked) || flush)});
      chk("imemaddr", imemaddr, pc_addr);
      chk("valid", {31'b0, valid}, {31'b0, m_valid});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_pc);
      chk("npc", npc, m_pc + 32'd4);
      chk("fetch_count", fetch_count, m_count);
    end
    if (RST) begin
      m_ok = 1'b1; m_valid = 1'b0; m_instr = '0; m_pc = RPC; m_count = '0;
      m_parked.delete();
    end else if (m_ok) begin
      if (flush) begin
        m_valid = 1'b0;
        m_parked.delete();
      end else begin
        if (!parked && ihit) m_parked.push_back({imemload, pc_addr});
        if (m_valid && !stall) m_valid = 1'b0;
        if (!m_valid && m_parked.size() != 0) begin
          {m_instr, m_pc} = m_parked.pop_front();
          m_valid = 1'b1;
          m_count = m_count + 32'd1;
        end
      end
    end
  end

  task automatic set(input logic r, input logic h, input logic [31:0] ld,
                     input logic [31:0] pc, input logic s, input logic f);
    RST = r; ihit = h; imemload = ld; pc_addr = pc; stall = s; flush = f;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    set(1, 1, 32'hDEAD_BEEF, 32'h0, 0, 0);
    chk("rst_pcenable", {31'b0, pcenable}, 32'h0);
    chk("rst_imemREN", {31'b0, imemREN}, 32'h0);
    tick(); tick();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, RPC);
    chk("rst_npc", npc, RPC + 32'd4);
    chk("rst_count", fetch_count, 32'h0);

    // Back-to-back hits at pc 0 with no stall.
    set(0, 1, 32'h2001_0005, 32'h0, 0, 0);
    chk("first_req", {31'b0, imemREN}, 32'h1);
    chk("b2b_pcen", {31'b0, pcenable}, 32'h1);
    tick();
    chk("b2b_valid", {31'b0, valid}, 32'h1);
    chk("b2b_instr", instr, 32'h2001_0005);
    chk("b2b_npc", npc, 32'h4);
    chk("b2b_cnt1", fetch_count, 32'h1);
    tick(); tick(); tick();
    chk("b2b_cnt4", fetch_count, 32'h4);

    // Stalled output forces the next word into HOLD.
    set(0, 1, 32'hAAAA_0000, 32'h8, 1, 0);
    tick();
    set(0, 0, 32'h0, 32'h8, 1, 0);
    chk("hold_ren", {31'b0, imemREN}, 32'h0);
    chk("hold_instr", instr, 32'h2001_0005);
    tick();
    chk("hold_stay", instr, 32'h2001_0005);
    set(0, 0, 32'h0, 32'hC, 0, 0);
    tick();
    chk("unhold_instr", instr, 32'hAAAA_0000);
    chk("unhold_pc", instr_pc, 32'h8);
    chk("unhold_cnt", fetch_count, 32'h5);
    chk("unhold_ren", {31'b0, imemREN}, 32'h1);

    // Memory wait at 0x40.
    set(0, 0, 32'h0, 32'h40, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("wait_ren", {31'b0, imemREN}, 32'h1);
      chk("wait_addr", imemaddr, 32'h40);
      chk("wait_pcen", {31'b0, pcenable}, 32'h0);
      tick();
    end
    chk("wait_valid", {31'b0, valid}, 32'h0);

    // Flush with a hit while in HOLD.
    set(0, 1, 32'h0000_0011, 32'h40, 0, 0);
    tick();
    set(0, 1, 32'h0000_0022, 32'h44, 1, 0);
    tick();
    set(0, 1, 32'h0000_0033, 32'h48, 1, 1);
    chk("flush_pcen", {31'b0, pcenable}, 32'h1);
    tick();
    chk("flush_valid", {31'b0, valid}, 32'h0);
    chk("flush_cnt", fetch_count, 32'h6);
    set(0, 0, 32'h0, 32'h80, 0, 0);
    chk("flush_ren", {31'b0, imemREN}, 32'h1);
    tick();
    chk("skid_empty", {31'b0, valid}, 32'h0);

    // npc wrap at the top of the address space.
    set(0, 1, 32'h0000_0005, 32'hFFFF_FFFC, 0, 0);
    tick();
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_npc", npc, 32'h0);

    // Reset while a request is pending.
    set(0, 0, 32'h0, 32'h100, 0, 0);
    tick();
    set(1, 1, 32'h1234_5678, 32'h100, 0, 0);
    chk("rstw_pcen", {31'b0, pcenable}, 32'h0);
    tick();
    chk("rstw_valid", {31'b0, valid}, 32'h0);
    chk("rstw_cnt", fetch_count, 32'h0);

    // Mixed traffic, checked by the per-cycle model.
    for (int i = 0; i < 300; i++) begin
      set(0, (i % 3) != 0, 32'hC000_0000 + i, 32'h1000 + 4 * i,
          (i % 5) == 1 || (i % 7) == 3, (i % 17) == 9);
      tick();
    end
    set(0, 0, 32'h0, 32'h0, 0, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
